// File: rtl/spram_pkg.sv
// Shared types and default parameter values for the pipelined single-port RAM.
package spram_pkg;

    // Control FSM: sweep the array with zeros, then serve requests.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_RD_LAT    = 2;
    localparam int DEF_INIT_ZERO = 1;

endpackage

// File: rtl/spram_core.sv
// Single-port synchronous RAM: byte-lane writes, one-cycle registered read.
// The array itself has no reset; only the read register is cleared so the
// read path starts from a known value.
module spram_core
    import spram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_be,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write only the byte lanes whose enable bit is set.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (i_be[k]) begin
                    r_mem[i_addr][k*8 +: 8] <= i_wdata[k*8 +: 8];
                end
            end
        end
    end

    // Registered read; holds its value between reads.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spram_pipe.sv
// Pipelined single-port RAM with optional zero-fill after reset.
// Read latency RD_LAT (legal 1..4) = 1 cycle in the core + RD_LAT-1 stages here.
module spram_pipe
    import spram_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int INIT_ZERO = DEF_INIT_ZERO
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_we_en,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_data_in,
    input  logic [DATA_W/8-1:0]   i_be,
    output logic                  o_ready,
    output logic [DATA_W-1:0]     o_data_out,
    output logic                  o_rd_valid,
    output logic                  o_init_done
);

    localparam int BE_W = DATA_W / 8;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic                r_ready;
    logic                r_init_done;
    logic                r_rd_vld0;

    logic                w_accept;
    logic                w_init_wr;
    logic                w_core_we;
    logic                w_core_re;
    logic [ADDR_W-1:0]   w_core_addr;
    logic [DATA_W-1:0]   w_core_wdata;
    logic [BE_W-1:0]     w_core_be;
    logic [DATA_W-1:0]   w_core_rdata;

    // Per-stage view of the read pipeline; index 0 is the core's read register.
    logic [RD_LAT-1:0]   w_vld;
    logic [DATA_W-1:0]   w_dat [RD_LAT];

    // Requests are only seen in RUN; the zero sweep owns the port in INIT.
    assign w_accept     = i_enable & r_ready;
    assign w_init_wr    = (r_state == ST_INIT) && (INIT_ZERO != 0);
    assign w_core_we    = w_init_wr | (w_accept & i_we_en);
    assign w_core_re    = w_accept & ~i_we_en;
    assign w_core_addr  = w_init_wr ? r_init_cnt : i_addr;
    assign w_core_wdata = w_init_wr ? '0 : i_data_in;
    assign w_core_be    = w_init_wr ? '1 : i_be;

    spram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_core_we),
        .i_re    (w_core_re),
        .i_addr  (w_core_addr),
        .i_wdata (w_core_wdata),
        .i_be    (w_core_be),
        .o_rdata (w_core_rdata)
    );

    // Control FSM: one address per cycle in INIT, leave after the last address.
    // The counter stops at DEPTH-1 so it never starts a second sweep.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            if ((INIT_ZERO == 0) || (&r_init_cnt)) begin
                r_state     <= ST_RUN;
                r_ready     <= 1'b1;
                r_init_done <= 1'b1;
            end else begin
                r_init_cnt  <= r_init_cnt + 1'b1;
            end
        end
    end

    // Valid bit that travels alongside the core's registered read data.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_vld0 <= 1'b0;
        end else begin
            r_rd_vld0 <= w_core_re;
        end
    end

    assign w_vld[0] = r_rd_vld0;
    assign w_dat[0] = w_core_rdata;

    // Extra output stages; data only moves with a valid entry, so the last
    // stage holds the most recent read result while no read is returning.
    genvar gi;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
            logic              r_vld;
            logic [DATA_W-1:0] r_dat;

            // Advance one pipeline stage.
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    r_vld <= 1'b0;
                    r_dat <= '0;
                end else begin
                    r_vld <= w_vld[gi-1];
                    if (w_vld[gi-1]) begin
                        r_dat <= w_dat[gi-1];
                    end
                end
            end

            assign w_vld[gi] = r_vld;
            assign w_dat[gi] = r_dat;
        end
    endgenerate

    assign o_ready     = r_ready;
    assign o_init_done = r_init_done;
    assign o_rd_valid  = w_vld[RD_LAT-1];
    assign o_data_out  = w_dat[RD_LAT-1];

endmodule

// File: tb/tb_spram_pipe.sv
// Scoreboard bench for spram_pipe: a reference memory array predicts every
// read; a negedge monitor pops expectations whenever rd_valid is seen.
// A second instance (RD_LAT=4, no zero-fill) gets a short directed check.
module tb_spram_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rst_n;
    logic        enable;
    logic        we_en;
    logic [5:0]  addr;
    logic [31:0] data_in;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        init_done;

    // Instance B: RD_LAT=4, INIT_ZERO=0
    logic        rst_b;
    logic        b_enable;
    logic        b_we_en;
    logic [5:0]  b_addr;
    logic [31:0] b_data_in;
    logic [3:0]  b_be;
    logic        b_ready;
    logic [31:0] b_data_out;
    logic        b_rd_valid;
    logic        b_init_done;

    spram_pipe u_dut_a (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_enable    (enable),
        .i_we_en     (we_en),
        .i_addr      (addr),
        .i_data_in   (data_in),
        .i_be        (be),
        .o_ready     (ready),
        .o_data_out  (data_out),
        .o_rd_valid  (rd_valid),
        .o_init_done (init_done)
    );

    spram_pipe #(
        .RD_LAT    (4),
        .INIT_ZERO (0)
    ) u_dut_b (
        .i_clk       (clk),
        .i_reset     (rst_b),
        .i_enable    (b_enable),
        .i_we_en     (b_we_en),
        .i_addr      (b_addr),
        .i_data_in   (b_data_in),
        .i_be        (b_be),
        .o_ready     (b_ready),
        .o_data_out  (b_data_out),
        .o_rd_valid  (b_rd_valid),
        .o_init_done (b_init_done)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] q_data [$];
    int          q_cyc  [$];
    logic [31:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: in reset everything is forced low; otherwise each rd_valid
    // pops one expectation and quiet cycles must hold the last read value.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_exp = '0;
            chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
            chk("rst_ready", {31'd0, ready}, 32'd0);
            chk("rst_data_out", data_out, 32'd0);
        end else if (rd_valid) begin
            if (q_data.size() == 0) begin
                chk("spurious_rd_valid", {31'd0, rd_valid}, 32'd0);
            end else begin
                logic [31:0] e;
                int          c;
                e = q_data.pop_front();
                c = q_cyc.pop_front();
                chk("rd_data", data_out, e);
                chk("rd_cycle", cyc, c);
                last_exp = e;
            end
        end else begin
            chk("data_hold", data_out, last_exp);
        end
    end

    // One cycle on instance A, starting just after a rising edge.
    // A read accepted at edge N is visible in the cycle ending at edge N+2.
    task automatic req(input bit en, input bit we, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input bit use_exp, input logic [31:0] ex);
        enable  = en;
        we_en   = we;
        addr    = a;
        data_in = d;
        be      = b;
        @(posedge clk);
        #1;
        if (en) begin
            if (we) begin
                for (int l = 0; l < 4; l++)
                    if (b[l]) ref_mem[a][l*8 +: 8] = d[l*8 +: 8];
            end else begin
                q_data.push_back(use_exp ? ex : ref_mem[a]);
                q_cyc.push_back(cyc + 1);
            end
        end
        enable = 1'b0;
    endtask

    task automatic assert_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        q_data.delete();
        q_cyc.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // After release: ready must stay low for exactly 64 sampled cycles.
    task automatic wait_init();
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (ready) break;
            chk("init_done_low", {31'd0, init_done}, 32'd0);
            n++;
        end
        chk("init_len", n, 32'd64);
        chk("init_done_high", {31'd0, init_done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_data.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", q_data.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; we_en = 1'b0; addr = '0; data_in = '0; be = '0;
        rst_b = 1'b0; b_enable = 1'b0; b_we_en = 1'b0; b_addr = '0; b_data_in = '0; b_be = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        #2;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_init_done", {31'd0, init_done}, 32'd0);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_data_out", data_out, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init();

        // Top address is zero after the sweep.
        req(1, 0, 6'h3F, 0, 0, 1, 32'h0);
        // Partial-lane overwrite.
        req(1, 1, 6'd5, 32'hDEADBEEF, 4'b1111, 0, 0);
        req(1, 1, 6'd5, 32'h000000AA, 4'b0001, 0, 0);
        req(1, 0, 6'd5, 0, 0, 1, 32'hDEADBEAA);
        // be=0 write leaves memory alone.
        req(1, 1, 6'd5, 32'h12345678, 4'b0000, 0, 0);
        req(1, 0, 6'd5, 0, 0, 1, 32'hDEADBEAA);
        // Back-to-back reads in order.
        req(1, 1, 6'd1, 32'h11, 4'hF, 0, 0);
        req(1, 1, 6'd2, 32'h22, 4'hF, 0, 0);
        req(1, 1, 6'd3, 32'h33, 4'hF, 0, 0);
        req(1, 0, 6'd1, 0, 0, 1, 32'h11);
        req(1, 0, 6'd2, 0, 0, 1, 32'h22);
        req(1, 0, 6'd3, 0, 0, 1, 32'h33);
        // Read right after a write to the same address.
        req(1, 1, 6'd9, 32'h55, 4'hF, 0, 0);
        req(1, 0, 6'd9, 0, 0, 1, 32'h55);
        // In-flight read returns pre-write data.
        req(1, 1, 6'd7, 32'h77, 4'hF, 0, 0);
        req(1, 0, 6'd7, 0, 0, 1, 32'h77);
        req(1, 1, 6'd7, 32'h99, 4'hF, 0, 0);
        req(1, 0, 6'd7, 0, 0, 1, 32'h99);
        // Idle cycles and enable with ready.
        req(0, 0, 6'd7, 0, 0, 0, 0);
        req(0, 1, 6'd7, 32'hFFFFFFFF, 4'hF, 0, 0);
        req(1, 0, 6'd7, 0, 0, 1, 32'h99);

        // Randomised traffic against the reference array.
        for (int i = 0; i < 400; i++) begin
            req($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)), 0, 0);
        end
        drain();

        // Reset while a read is in flight: result must never appear.
        req(1, 0, 6'd9, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        assert_reset();
        wait_init();
        req(1, 0, 6'd5, 0, 0, 1, 32'h0);
        drain();

        // Reset in the middle of INIT restarts the full sweep.
        @(posedge clk);
        #1;
        assert_reset();
        repeat (20) @(posedge clk);
        #1;
        chk("mid_init_ready", {31'd0, ready}, 32'd0);
        assert_reset();
        wait_init();
        req(1, 0, 6'd63, 0, 0, 1, 32'h0);
        drain();

        // Instance B: no sweep, latency 4.
        begin
            logic [31:0] v;
            int          n_acc;
            int          vc;
            v = $urandom;
            @(posedge clk);
            #1;
            rst_b = 1'b1;
            @(posedge clk);
            #1;
            chk("b_ready_first", {31'd0, b_ready}, 32'd1);
            chk("b_init_done_first", {31'd0, b_init_done}, 32'd1);
            b_enable = 1'b1; b_we_en = 1'b1; b_addr = 6'd3; b_data_in = v; b_be = 4'hF;
            @(posedge clk);
            #1;
            b_we_en = 1'b0;
            @(posedge clk);
            #1;
            n_acc = cyc;
            b_enable = 1'b0;
            vc = -1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (b_rd_valid) begin
                    vc = cyc;
                    break;
                end
            end
            chk("b_rd_cycle", vc, n_acc + 3);
            chk("b_rd_data", b_data_out, v);
            @(negedge clk);
            chk("b_rd_pulse", {31'd0, b_rd_valid}, 32'd0);
            chk("b_data_hold", b_data_out, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spram_pipe.md
SPRAM_PIPE -- requirements
Module: spram_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter RD_LAT, default 2, giving the read latency in cycles; the legal range is 1..4.
REQ-004 The block SHALL have parameter INIT_ZERO, default 1; when 1, the memory is cleared after reset.
REQ-005 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  request valid.
REQ-008 we_en  input  1  request type: 1 = write, 0 = read.
REQ-009 addr  input  ADDR_W  word address.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 be  input  DATA_W/8  byte-lane write enables; ignored on reads.
REQ-012 ready  output  1  the block can accept a request this cycle.
REQ-013 data_out  output  DATA_W  read data.
REQ-014 rd_valid  output  1  data_out carries a read result this cycle.
REQ-015 init_done  output  1  memory initialisation is complete.

Function
REQ-016 A request SHALL be accepted on any rising clk edge where enable=1 and ready=1; all other cycles are no-ops.
REQ-017 The control FSM SHALL have two states: INIT and RUN.
  - After reset release, the FSM enters INIT if INIT_ZERO=1, otherwise RUN.
REQ-018 In INIT, an internal counter SHALL write zero to addresses 0..DEPTH-1, one address per cycle.
  - The transition INIT -> RUN occurs after the cycle that writes DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-019 ready and init_done SHALL both be 0 in INIT and 1 in RUN; in INIT, enable is ignored.
REQ-020 An accepted write SHALL update only the byte lanes whose be bit is 1, at the accepting edge; be=0 leaves the memory unchanged.
REQ-021 An accepted read SHALL assert rd_valid for exactly one cycle, RD_LAT cycles after the accepting edge, with data_out = mem[addr] as of that edge.
REQ-022 Back-to-back reads SHALL be accepted every cycle at full throughput, and their results SHALL return in request order.
REQ-023 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-024 Writes SHALL never assert rd_valid.
  - A read pipeline entry already in flight is unaffected by a later write and returns the pre-write data.
REQ-025 data_out SHALL hold its last read value while rd_valid=0.
REQ-026 The address counter SHALL be ADDR_W bits wide and SHALL NOT wrap into a second sweep.

Reset
REQ-027 On assertion of reset (reset=0), the block SHALL immediately force the following, regardless of clk:
  - ready=0, rd_valid=0, data_out=0, init_done=0;
  - all read-pipeline valid bits cleared;
  - the FSM to INIT and the init counter to 0.
REQ-028 Reset asserted mid-INIT or mid-read SHALL discard in-flight reads, which are never reported, and SHALL restart initialisation from address 0.
REQ-029 Memory array contents SHALL NOT be reset directly.
  - They are defined only after INIT completes (INIT_ZERO=1) or after being written.

Structure
REQ-030 Package spram_pkg SHALL hold the FSM state enum (INIT, RUN) and the default parameter constants.
REQ-031 The storage array SHALL be a separate sub-module spram_core.
  - It is a 1-port synchronous RAM with a write-enable, byte enables and a 1-cycle registered read.
  - spram_pipe adds RD_LAT-1 output pipeline stages on top of it.

Verification
REQ-032 Reset, then release with INIT_ZERO=1, DEPTH=64: ready=0 for exactly 64 cycles, then ready=1 and init_done=1; a read of address 0x3F then returns 0.
REQ-033 Write 0xDEADBEEF to address 5 with be=4'b1111, then write 0x000000AA to address 5 with be=4'b0001, then read address 5: data_out=0xDEADBEAA, with rd_valid exactly 2 cycles after the read is accepted.
REQ-034 Issue reads of addresses 1, 2, 3 on consecutive cycles after writing values 0x11, 0x22, 0x33 to them: rd_valid is high for 3 consecutive cycles with data 0x11, 0x22, 0x33 in order.
REQ-035 Write 0x55 to address 9, then read address 9 on the next cycle: the read returns 0x55.
REQ-036 Accept a read, then assert reset 1 cycle later: rd_valid never rises, and after release the INIT sweep restarts from address 0.
REQ-037 RD_LAT=4, INIT_ZERO=0: after reset release, ready=1 on the first cycle; a write followed by a read returns the written data with rd_valid 4 cycles after acceptance.
